// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding and bus-level constants for the I2C register target
package i2c_pkg;
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
  } state_t;
  localparam logic ACK = 1'b0;
  localparam logic NACK = 1'b1;
  localparam logic [7:0] RD_MISS = 8'hFF;
  function automatic logic drives_ack(input state_t s);
    return s inside {ADDR_ACK, PTR_ACK, WDATA_ACK};
  endfunction
endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: synchronizes SCL/SDA and flags SCL edges, START and STOP
module i2c_line_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);
  logic [STAGES-1:0] scl_sync, sda_sync;
  logic scl, scl_q, sda_q;
  // Idle-high synchronizer chains plus one cycle of history for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[STAGES-2:0], sda_in};
      scl_q <= scl_sync[STAGES-1];
      sda_q <= sda_sync[STAGES-1];
    end
  end
  // Bus conditions: SDA moving while SCL stays high marks START/STOP
  always_comb begin
    scl = scl_sync[STAGES-1];
    sda = sda_sync[STAGES-1];
    scl_rise = scl & ~scl_q;
    scl_fall = ~scl & scl_q;
    start = scl & scl_q & sda_q & ~sda;
    stop = scl & scl_q & ~sda_q & sda;
  end
endmodule

// File: rtl/i2c_reg_target.sv
// i2c_reg_target: I2C target exposing a byte register file with auto-incrementing pointer
module i2c_reg_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] CHIP_ADDR = 7'h39,
  parameter int NUM_REGS = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       busy,
  output logic       wr_stb,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic [7:0] host_addr,
  output logic [7:0] host_data
);
  localparam int IW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
  state_t state, state_nx;
  logic sda, scl_rise, scl_fall, start, stop;
  logic [7:0] shift, tx, ptr;
  logic [3:0] bit_cnt;
  logic [7:0] regs [NUM_REGS];
  logic byte_end, ptr_ok, host_ok, sda_bit;

  i2c_line_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .reset(reset),
    .scl_in(scl_in),
    .sda_in(sda_in),
    .sda(sda),
    .scl_rise(scl_rise),
    .scl_fall(scl_fall),
    .start(start),
    .stop(stop)
  );

  // State register; busy rises on an address match and drops at STOP or address NACK
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
    end else begin
      state <= state_nx;
      busy <= (state_nx == IDLE || (state == ADDR && state_nx == WAIT_STOP)) ? 1'b0 :
              state_nx == ADDR_ACK ? 1'b1 : busy;
    end
  end

  // Next state: STOP beats START, both beat byte progress; bytes advance on SCL falls
  always_comb begin
    state_nx = state;
    byte_end = scl_fall && bit_cnt == 4'd8;
    if (stop) state_nx = IDLE;
    else if (start) state_nx = ADDR;
    else if (scl_fall)
      case (state)
        ADDR:      if (byte_end) state_nx = shift[7:1] == CHIP_ADDR ? ADDR_ACK : WAIT_STOP;
        ADDR_ACK:  state_nx = shift[0] ? RDATA : PTR;
        PTR:       if (byte_end) state_nx = PTR_ACK;
        PTR_ACK:   state_nx = WDATA;
        WDATA:     if (byte_end) state_nx = WDATA_ACK;
        WDATA_ACK: state_nx = WDATA;
        RDATA:     if (byte_end) state_nx = RDATA_ACK;
        RDATA_ACK: state_nx = shift[0] == NACK ? WAIT_STOP : RDATA;
        default:   state_nx = state;
      endcase
  end

  // SDA pull-down: ACK slots drive ACK, read data drives the current MSB, else released
  always_comb begin
    ptr_ok = {1'b0, ptr} < 9'(NUM_REGS);
    host_ok = {1'b0, host_addr} < 9'(NUM_REGS);
    sda_bit = drives_ack(state) ? ACK : state == RDATA ? tx[7] : 1'b1;
    sda_oe = ~sda_bit;
  end

  // Datapath: bit counting, byte shifting, pointer, register writes and host read port
  always_ff @(posedge clk) begin
    wr_stb <= 1'b0;
    if (reset) begin
      shift <= '0;
      tx <= '0;
      ptr <= '0;
      bit_cnt <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      host_data <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      host_data <= host_ok ? regs[host_addr[IW-1:0]] : RD_MISS;
      if (start || stop || state_nx != state) bit_cnt <= '0;
      else if (scl_rise && bit_cnt != 4'd8 && state inside {ADDR, PTR, WDATA, RDATA}) bit_cnt <= bit_cnt + 4'd1;
      if (scl_rise && state inside {ADDR, PTR, WDATA, RDATA_ACK}) shift <= {shift[6:0], sda};
      if (state == PTR && state_nx == PTR_ACK) ptr <= shift;
      else if ((state == WDATA && state_nx == WDATA_ACK) || (state == RDATA && state_nx == RDATA_ACK)) ptr <= ptr + 8'd1;
      if (state == WDATA && state_nx == WDATA_ACK && ptr_ok) begin
        regs[ptr[IW-1:0]] <= shift;
        wr_stb <= 1'b1;
        wr_addr <= ptr;
        wr_data <= shift;
      end
      if (state_nx == RDATA && state != RDATA) tx <= ptr_ok ? regs[ptr[IW-1:0]] : RD_MISS;
      else if (state == RDATA && scl_fall) tx <= {tx[6:0], 1'b1};
    end
  end
endmodule

// File: tb/tb_i2c_reg_target.sv
// tb_i2c_reg_target: bit-banged I2C master with a transaction-level register model
module tb_i2c_reg_target;
  import i2c_pkg::*;
  localparam int Q = 4;
  logic clk = 1'b0, reset = 1'b1, scl_m = 1'b1, sda_m = 1'b1;
  logic sda_line, sda_oe, busy, wr_stb;
  logic [7:0] wr_addr, wr_data, host_data;
  logic [7:0] host_addr = 8'h00;
  int checks = 0, failures = 0, oe_cnt = 0, stb_cnt = 0;
  logic [7:0] mreg [16];
  logic [7:0] m_ptr = 8'h00;
  logic [15:0] expq [$];
  logic r_q = 1'b1, oe_q = 1'b0;
  logic [7:0] ha_q = 8'h00;

  assign sda_line = sda_m & ~sda_oe;

  i2c_reg_target dut (
    .clk(clk), .reset(reset), .scl_in(scl_m), .sda_in(sda_line), .sda_oe(sda_oe),
    .busy(busy), .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
    .host_addr(host_addr), .host_data(host_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // What the DUT sampled at each edge: reset and host read index
  always @(posedge clk) begin
    r_q <= reset;
    ha_q <= host_addr;
  end

  // Per-cycle compare: host read port, write strobes vs expected queue, SDA driven only with SCL low
  always @(negedge clk) begin
    logic [15:0] e;
    if (r_q) begin
      foreach (mreg[i]) mreg[i] = 8'h00;
      expq.delete();
    end else begin
      chk("host_data", host_data, ha_q < 8'd16 ? mreg[ha_q[3:0]] : 8'hFF);
      if (wr_stb) begin
        stb_cnt++;
        checks++;
        if (expq.size() == 0) begin
          failures++;
          $display("FAIL wr_stb_unexpected: got wr_addr=%0h wr_data=%0h expected no strobe", wr_addr, wr_data);
        end else begin
          e = expq.pop_front();
          chk("wr_addr", wr_addr, e[15:8]);
          chk("wr_data", wr_data, e[7:0]);
          mreg[e[11:8]] = e[7:0];
        end
      end
      if (sda_oe && !oe_q) begin
        checks++;
        if (scl_m) begin
          failures++;
          $display("FAIL oe_scl_high: got sda_oe rising with scl=1 expected scl=0");
        end
      end
    end
    if (sda_oe) oe_cnt++;
    oe_q = sda_oe;
  end

  task automatic wq;
    repeat (Q) @(negedge clk);
  endtask
  task automatic i2c_start;
    sda_m = 1'b1; wq; scl_m = 1'b1; wq; sda_m = 1'b0; wq; scl_m = 1'b0; wq;
  endtask
  task automatic i2c_stop;
    sda_m = 1'b0; wq; scl_m = 1'b1; wq; sda_m = 1'b1; wq;
  endtask
  task automatic send_bit(input logic b);
    sda_m = b; wq; scl_m = 1'b1; wq; wq; scl_m = 1'b0; wq;
  endtask
  task automatic recv_bit(output logic b);
    sda_m = 1'b1; wq; scl_m = 1'b1; wq; b = sda_line; wq; scl_m = 1'b0; wq;
  endtask
  task automatic write_byte(input logic [7:0] b, input logic exp_ack, input string name);
    logic a;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    recv_bit(a);
    chk(name, a, exp_ack ? ACK : NACK);
  endtask
  task automatic wr_data_byte(input logic [7:0] d);
    if (m_ptr < 8'd16) expq.push_back({m_ptr, d});
    m_ptr = m_ptr + 8'd1;
    write_byte(d, 1'b1, "ack_wdata");
  endtask
  task automatic rd_data_byte(input logic ack_bit, output logic [7:0] d);
    logic t;
    logic [7:0] exp;
    exp = m_ptr < 8'd16 ? mreg[m_ptr[3:0]] : 8'hFF;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(t);
      d[i] = t;
    end
    send_bit(ack_bit);
    chk("rdata_model", d, exp);
    m_ptr = m_ptr + 8'd1;
  endtask
  task automatic set_ptr(input logic [7:0] p);
    i2c_start;
    write_byte(8'h72, 1'b1, "ack_addr_w");
    write_byte(p, 1'b1, "ack_ptr");
    m_ptr = p;
  endtask
  task automatic peek(input logic [7:0] a, input logic [7:0] exp, input string name);
    host_addr = a;
    repeat (2) @(negedge clk);
    chk(name, host_data, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d;
    int s0, o0;
    repeat (4) @(negedge clk);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_stb", wr_stb, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_host_data", host_data, 0);
    reset = 1'b0;
    wq;
    s0 = stb_cnt;
    set_ptr(8'h03);
    chk("busy_in_xfer", busy, 1);
    wr_data_byte(8'hA5);
    i2c_stop;
    chk("busy_after_stop", busy, 0);
    chk("stb_count_1", stb_cnt - s0, 1);
    chk("wr_addr_lit", wr_addr, 8'h03);
    chk("wr_data_lit", wr_data, 8'hA5);
    peek(8'd3, 8'hA5, "host_reg3");
    set_ptr(8'h03);
    i2c_start;
    write_byte(8'h73, 1'b1, "ack_addr_r");
    rd_data_byte(1'b0, d);
    chk("rd_first_lit", d, 8'hA5);
    rd_data_byte(1'b1, d);
    chk("rd_second_lit", d, 8'h00);
    chk("busy_after_nack", busy, 1);
    i2c_stop;
    chk("busy_read_stop", busy, 0);
    o0 = oe_cnt;
    s0 = stb_cnt;
    i2c_start;
    write_byte(8'h70, 1'b0, "nack_addr");
    write_byte(8'h55, 1'b0, "nack_data");
    chk("wait_stop_state", dut.state, WAIT_STOP);
    chk("busy_foreign", busy, 0);
    i2c_stop;
    chk("idle_after_stop", dut.state, IDLE);
    chk("no_sda_pull", oe_cnt - o0, 0);
    chk("no_stb_foreign", stb_cnt - s0, 0);
    s0 = stb_cnt;
    set_ptr(8'h0F);
    wr_data_byte(8'h11);
    wr_data_byte(8'h22);
    i2c_stop;
    chk("burst_stb_count", stb_cnt - s0, 1);
    chk("burst_ptr", dut.ptr, 8'h11);
    peek(8'd15, 8'h11, "host_reg15");
    peek(8'd16, 8'hFF, "host_oor");
    i2c_start;
    write_byte(8'h73, 1'b1, "ack_addr_r2");
    rd_data_byte(1'b1, d);
    chk("rd_oor_lit", d, 8'hFF);
    i2c_stop;
    set_ptr(8'hFF);
    wr_data_byte(8'h33);
    wr_data_byte(8'h77);
    i2c_stop;
    chk("wrap_ptr", dut.ptr, 8'h01);
    peek(8'd0, 8'h77, "host_reg0_wrap");
    s0 = stb_cnt;
    set_ptr(8'h02);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    i2c_stop;
    chk("partial_no_stb", stb_cnt - s0, 0);
    peek(8'd2, 8'h00, "host_reg2_partial");
    set_ptr(8'h02);
    wr_data_byte(8'h5A);
    i2c_stop;
    peek(8'd2, 8'h5A, "host_reg2");
    set_ptr(8'h02);
    i2c_start;
    write_byte(8'h73, 1'b1, "ack_addr_r3");
    chk("rd_bit0_drive", sda_oe, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_release_sda", sda_oe, 0);
    chk("reset_busy", busy, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_ptr = 8'h00;
    scl_m = 1'b1; wq; sda_m = 1'b1; wq;
    peek(8'd2, 8'h00, "post_rst_reg2");
    peek(8'd15, 8'h00, "post_rst_reg15");
    peek(8'd0, 8'h00, "post_rst_reg0");
    chk("post_rst_wr_data", wr_data, 8'h00);
    set_ptr(8'h05);
    wr_data_byte(8'hC3);
    i2c_stop;
    peek(8'd5, 8'hC3, "host_reg5");
    set_ptr(8'h05);
    i2c_start;
    write_byte(8'h73, 1'b1, "ack_addr_r4");
    rd_data_byte(1'b1, d);
    chk("rd_after_rst_lit", d, 8'hC3);
    i2c_stop;
    wq;
    chk("pending_writes", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
